serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Time-shares one 1-bit full-adder cell across WIDTH

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_add_ctrl_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and WIDTH limits.
package serial_add_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder shared across all bit positions of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first over WIDTH cycles.
// Optional subtract port and logic enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] a_sh_nxt;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] b_sh_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             carry;
    logic             carry_nxt;
    logic             cout_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic             sub_sel;
    logic             cell_s;
    logic             cell_co;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_sh      <= a_sh_nxt;
            b_sh      <= b_sh_nxt;
            carry     <= carry_nxt;
            cnt       <= cnt_nxt;
            sum       <= sum_nxt;
            cout      <= cout_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        a_sh_nxt  = a_sh;
        b_sh_nxt  = b_sh;
        carry_nxt = carry;
        cnt_nxt   = cnt;
        sum_nxt   = sum;
        cout_nxt  = cout;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1, so the inverted operand and forced carry are loaded here.
                    a_sh_nxt  = a;
                    b_sh_nxt  = sub_sel ? ~b : b;
                    carry_nxt = sub_sel ? 1'b1 : cin;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_nxt  = a_sh >> 1;
                b_sh_nxt  = b_sh >> 1;
                carry_nxt = cell_co;
                sum_nxt   = (sum >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    cout_nxt  = cell_co;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        in_ready_nxt  = (state_nxt == ST_IDLE);
        out_valid_nxt = (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8 main instance plus a WIDTH=1 instance).
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif

    logic in_valid1, out_ready1, a1, b1, cin1;
    logic in_ready1, out_valid1, sum1, cout1;

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] sb_q[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        logic [W-1:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + (W + 1)'(s ? 1'b1 : c);
    endfunction

    // Result monitor: the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0)
                check("sb_pop_empty", 64'(sb_q.size()), 64'd1);
            else
                check("result", 64'({cout, sum}), 64'(sb_q.pop_front()));
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts, input int dly, input bit poke);
        int lat;
        int guard;
        logic [W:0] exp;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        exp      = model(ta, tb, tc, ts);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tc;
`ifdef SERIAL_ADD_SUB_EN
        sub      = ts;
`endif
        sb_q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("in_ready_busy", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < int'(W) + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(W));
        repeat (dly) begin
            if (poke) begin
                in_valid = ~in_valid;
                a        = 8'hA5;
            end
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            if (poke) begin
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_result", 64'({cout, sum}), 64'(exp));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W:0] e1;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'({cout, sum}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_result", 64'({cout, sum}), 64'd0);

        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);

        // Backpressure with ignored in_valid pulses while DONE.
        do_op(8'h3C, 8'h5A, 1'b1, 1'b0, 5, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_phantom_valid", 64'(out_valid), 64'd0);
            check("back_to_idle", 64'(in_ready), 64'd1);
        end

        // Reset mid-RUN discards the operation.
        @(negedge clk);
        in_valid = 1'b1; a = 8'h99; b = 8'h77; cin = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'({cout, sum}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op(8'h22, 8'h11, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0);
        do_op(8'h07, 8'h05, 1'b1, 1'b1, 0, 1'b0);
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, $urandom_range(0, 2), 1'b0);
        end

        // WIDTH=1 instance: exhaustive over a, b, cin.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("w1_in_ready", 64'(in_ready1), 64'd1);
            {a1, b1, cin1} = 3'(i);
            e1 = (W + 1)'(a1) + (W + 1)'(b1) + (W + 1)'(cin1);
            in_valid1 = 1'b1;
            @(posedge clk);
            #1 in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 5) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("w1_latency", 64'(lat), 64'd1);
            check("w1_result", 64'({cout1, sum1}), 64'(e1[1:0]));
            out_ready1 = 1'b1;
            @(posedge clk);
            #1 out_ready1 = 1'b0;
            check("w1_valid_drop", 64'(out_valid1), 64'd0);
        end

        repeat (2) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
